// File: rtl/acc_pkg.sv
// Shared constants for the map merger: FSM state codes, lane geometry, counter width.
package acc_pkg;
   localparam int BYTE_W = 8;
   localparam int LANES  = 4;
   localparam int CNT_W  = 24;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/map_merger_if.sv
// PE-result input stream and packed-word output stream of the map merger.
// master = merger side, slave = PE array / omap BIU side.
interface map_merger_if #(
   parameter int IN_DW  = 16,
   parameter int OUT_DW = 32
);
   logic [IN_DW-1:0]  pe2map_merger_data;
   logic              pe2map_merger_vld;
   logic              pe2map_merger_rdy;
   logic [OUT_DW-1:0] map_merger2omap_biu_data;
   logic              map_merger2omap_biu_vld;
   logic              map_merger2omap_biu_rdy;

   modport master (
      input  pe2map_merger_data, pe2map_merger_vld, map_merger2omap_biu_rdy,
      output pe2map_merger_rdy, map_merger2omap_biu_data, map_merger2omap_biu_vld
   );

   modport slave (
      output pe2map_merger_data, pe2map_merger_vld, map_merger2omap_biu_rdy,
      input  pe2map_merger_rdy, map_merger2omap_biu_data, map_merger2omap_biu_vld
   );
endinterface

// File: rtl/map_merger_quant.sv
// Requantizer: arithmetic right shift then saturate to one byte; purely combinational.
// MAP_MERGER_RELU_EN selects ReLU + unsigned [0,255]; otherwise signed [-128,127].
module map_merger_quant #(
   parameter int IN_DW  = 16,
   parameter int BYTE_W = acc_pkg::BYTE_W
) (
   input  logic signed [IN_DW-1:0] data,
   input  logic [3:0]              shift,
   output logic [BYTE_W-1:0]       q
);
`ifdef MAP_MERGER_RELU_EN
   localparam logic signed [IN_DW-1:0] U_MAX = IN_DW'((1 << BYTE_W) - 1);
`else
   localparam logic signed [IN_DW-1:0] S_MAX = IN_DW'((1 << (BYTE_W - 1)) - 1);
   localparam logic signed [IN_DW-1:0] S_MIN = IN_DW'(-(1 << (BYTE_W - 1)));
`endif

   logic signed [IN_DW-1:0] s;

   always_comb begin
      s = data >>> shift;
      q = s[BYTE_W-1:0];
`ifdef MAP_MERGER_RELU_EN
      if (s < '0)
         q = '0;
      else if (s > U_MAX)
         q = '1;
`else
      if (s < S_MIN)
         q = {1'b1, {(BYTE_W-1){1'b0}}};
      else if (s > S_MAX)
         q = {1'b0, {(BYTE_W-1){1'b1}}};
`endif
   end
endmodule

// File: rtl/map_merger.sv
// Requantizes PE results to bytes, packs 4 per word (lane 0 first), flushes a zero-padded tail, pulses merge_done.
// Latency: 1 cycle from completing accept to output vld; input stalls while an unaccepted word is held.
// Build option: MAP_MERGER_RELU_EN (ReLU/unsigned saturation in map_merger_quant).
module map_merger #(
   parameter int IN_DW  = 16,
   parameter int OUT_DW = 32,
   parameter int BYTE_W = acc_pkg::BYTE_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  out_ch,
   input  logic [15:0] map_size,
   input  logic [3:0]  shift,
   input  logic        conv_start,
   map_merger_if.master bus,
   output logic        merge_done,
   output logic        busy
);
   import acc_pkg::*;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic [CNT_W-1:0]  elem_cnt_q, elem_cnt_d;
   logic [3:0]        shift_q, shift_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [OUT_DW-1:0] pack_q, pack_d;
   logic [OUT_DW-1:0] out_dat_q, out_dat_d;
   logic              out_vld_q, out_vld_d;

   logic [CNT_W-1:0]  start_total;
   logic [BYTE_W-1:0] qbyte;
   logic [OUT_DW-1:0] word;
   logic              in_rdy, accept, last, emit, out_hs;

   map_merger_quant #(.IN_DW(IN_DW), .BYTE_W(BYTE_W)) u_quant (
      .data  (bus.pe2map_merger_data),
      .shift (shift_q),
      .q     (qbyte)
   );

   assign start_total = CNT_W'(map_size) * CNT_W'(out_ch);
   assign out_hs      = out_vld_q && bus.map_merger2omap_biu_rdy;
   assign in_rdy      = (state_q == ST_RUN) && (!out_vld_q || bus.map_merger2omap_biu_rdy);
   assign accept      = bus.pe2map_merger_vld && in_rdy;
   assign last        = (elem_cnt_q == total_q - CNT_W'(1));
   assign emit        = accept && ((byte_idx_q == 2'd3) || last);

   assign bus.pe2map_merger_rdy       = in_rdy;
   assign bus.map_merger2omap_biu_data = out_dat_q;
   assign bus.map_merger2omap_biu_vld  = out_vld_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         total_q    <= '0;
         elem_cnt_q <= '0;
         shift_q    <= '0;
         byte_idx_q <= '0;
         pack_q     <= '0;
         out_dat_q  <= '0;
         out_vld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         total_q    <= total_d;
         elem_cnt_q <= elem_cnt_d;
         shift_q    <= shift_d;
         byte_idx_q <= byte_idx_d;
         pack_q     <= pack_d;
         out_dat_q  <= out_dat_d;
         out_vld_q  <= out_vld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (conv_start) state_d = (start_total == '0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (accept && last) state_d = ST_DRAIN;
         ST_DRAIN: if (out_hs) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_IDLE);
      merge_done = (state_q == ST_DONE);
   end

   // Lanes above byte_idx are still zero in pack_q, which gives the padded flush for free.
   always_comb begin
      word = pack_q;
      for (int i = 0; i < LANES; i++) begin
         if (byte_idx_q == 2'(i))
            word[i*BYTE_W +: BYTE_W] = qbyte;
      end
   end

   always_comb begin
      total_d    = total_q;
      shift_d    = shift_q;
      elem_cnt_d = elem_cnt_q;
      byte_idx_d = byte_idx_q;
      pack_d     = pack_q;
      out_dat_d  = out_dat_q;
      out_vld_d  = out_vld_q;

      if (state_q == ST_IDLE && conv_start) begin
         total_d    = start_total;
         shift_d    = shift;
         elem_cnt_d = '0;
         byte_idx_d = '0;
         pack_d     = '0;
      end

      if (accept) begin
         elem_cnt_d = elem_cnt_q + CNT_W'(1);
         if (emit) begin
            byte_idx_d = '0;
            pack_d     = '0;
         end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            pack_d     = word;
         end
      end

      // A new load may coincide with the handshake of the held word.
      if (emit) begin
         out_dat_d = word;
         out_vld_d = 1'b1;
      end else if (out_hs) begin
         out_vld_d = 1'b0;
      end
   end
endmodule
